// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - writeback select encodings and writeback scheduler FSM state
package msrv32_pkg;

  localparam int unsigned WB_SEL_W = 3;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_ALU     = 3'b000,
    WB_LU      = 3'b001,
    WB_IMM     = 3'b010,
    WB_IADDER  = 3'b011,
    WB_CSR     = 3'b100,
    WB_PC_PLUS = 3'b101
  } wb_sel_e;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/msrv32_wb_timeout_ctr.sv
// rtl/msrv32_wb_timeout_ctr.sv - load wait counter with clear, enable and expire
module msrv32_wb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear dominates so the counter is zero on every entry into the wait state.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/msrv32_wb_sched.sv
// rtl/msrv32_wb_sched.sv - writeback scheduler; MSRV32_WB_TIMEOUT_EN adds the load timeout path
module msrv32_wb_sched
  import msrv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                issue_valid_in,
  input  logic [WB_SEL_W-1:0] wb_sel_in,
  input  logic [4:0]          rd_in,
  input  logic                rf_we_in,
  input  logic                dmem_ack_in,
  input  logic                flush_in,
  output logic [WB_SEL_W-1:0] wb_mux_sel_reg_out,
  output logic [4:0]          rd_reg_out,
  output logic                rf_wr_en_out,
  output logic                stall_out,
  output logic                load_fault_out
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  wb_state_e           state_q, state_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic [4:0]          rd_q, rd_d;
  logic                we_q, we_d;
  logic                wr_en_q, wr_en_d;
  logic                timeout;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rd_d      = rd_q;
    we_d      = we_q;
    wr_en_d   = 1'b0;
    stall_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_valid_in && !flush_in) begin
          sel_d = wb_sel_in;
          rd_d  = rd_in;
          we_d  = rf_we_in;
          if (wb_sel_in == WB_LU && !dmem_ack_in) begin
            state_d   = WAIT_LD;
            stall_out = 1'b1;
          end else begin
            wr_en_d = rf_we_in && (rd_in != 5'd0);
          end
        end
      end
      WAIT_LD: begin
        // Flush beats ack, and ack beats timeout.
        if (flush_in) begin
          state_d = IDLE;
        end else if (dmem_ack_in) begin
          state_d = IDLE;
          wr_en_d = we_q && (rd_q != 5'd0);
        end else if (timeout) begin
          state_d = IDLE;
        end else begin
          stall_out = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      wr_en_q <= wr_en_d;
    end
  end

`ifdef MSRV32_WB_TIMEOUT_EN
  logic fault_q;
  logic ctr_clear;
  logic ctr_en;
  logic fault_evt;

  assign ctr_clear = (state_q != WAIT_LD) || (state_d != WAIT_LD);
  assign ctr_en    = (state_q == WAIT_LD) && !dmem_ack_in;
  assign fault_evt = (state_q == WAIT_LD) && !flush_in && !dmem_ack_in && timeout;

  msrv32_wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i   (clk_in),
    .rst_ni  (rst_n_in),
    .clear_i (ctr_clear),
    .en_i    (ctr_en),
    .expire_o(timeout)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_evt;
    end
  end

  assign load_fault_out = fault_q;
`else
  assign timeout        = 1'b0;
  assign load_fault_out = 1'b0;
`endif

  assign wb_mux_sel_reg_out = sel_q;
  assign rd_reg_out         = rd_q;
  assign rf_wr_en_out       = wr_en_q;

`ifndef SYNTHESIS
  a_no_issue_while_waiting: assert property (@(posedge clk_in) disable iff (!rst_n_in)
    !(state_q == WAIT_LD && issue_valid_in));
`endif

endmodule

// File: tb/tb_msrv32_wb_sched.sv
// tb/tb_msrv32_wb_sched.sv - scoreboard bench for msrv32_wb_sched against a transaction-level model
module tb_msrv32_wb_sched;

  localparam int T = 4;
`ifdef MSRV32_WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic [2:0] wb_sel = 3'd0;
  logic [4:0] rd = 5'd0;
  logic       rf_we = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] sel_reg;
  logic [4:0] rd_reg;
  logic       wr_en;
  logic       stall;
  logic       fault;

  msrv32_wb_sched #(.TIMEOUT_CYCLES(T)) dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .issue_valid_in    (issue_valid),
    .wb_sel_in         (wb_sel),
    .rd_in             (rd),
    .rf_we_in          (rf_we),
    .dmem_ack_in       (dmem_ack),
    .flush_in          (flush),
    .wb_mux_sel_reg_out(sel_reg),
    .rd_reg_out        (rd_reg),
    .rf_wr_en_out      (wr_en),
    .stall_out         (stall),
    .load_fault_out    (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         due;
    logic [4:0] rd;
    logic [2:0] sel;
  } wr_t;

  wr_t wq[$];
  int  fq[$];

  // Model: a pending load waiting for data, plus the last accepted issue.
  bit         m_pend = 1'b0;
  bit         m_pwe = 1'b0;
  int         m_wait = 0;
  logic [4:0] m_lat_rd = 5'd0;
  logic [2:0] m_lat_sel = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en === 1'b1) begin
        chk("wr_strobe_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_cycle", cyc, e.due);
          chk("wr_rd", rd_reg, e.rd);
          chk("wr_sel", sel_reg, e.sel);
        end
      end else if (wq.size() != 0 && wq[0].due <= cyc) begin
        chk("wr_strobe_missing", wr_en, 1);
        void'(wq.pop_front());
      end
      if (fault === 1'b1) begin
        chk("fault_expected", 32'(fq.size() != 0), 32'd1);
        if (fq.size() != 0) chk("fault_cycle", cyc, fq.pop_front());
      end else if (fq.size() != 0 && fq[0] <= cyc) begin
        chk("fault_missing", fault, 1);
        void'(fq.pop_front());
      end
    end
  end

  task automatic step(input bit iv, input logic [2:0] s, input logic [4:0] r,
                      input bit we, input bit ack, input bit fl);
    bit exp_stall;
    @(negedge clk);
    chk("rd_reg_hold", rd_reg, m_lat_rd);
    chk("sel_reg_hold", sel_reg, m_lat_sel);
    issue_valid = iv;
    wb_sel      = s;
    rd          = r;
    rf_we       = we;
    dmem_ack    = ack;
    flush       = fl;
    exp_stall   = 1'b0;
    if (!m_pend) begin
      if (iv && !fl) begin
        m_lat_rd  = r;
        m_lat_sel = s;
        if (s == 3'b001 && !ack) begin
          m_pend    = 1'b1;
          m_pwe     = we;
          m_wait    = 0;
          exp_stall = 1'b1;
        end else if (we && r != 5'd0) begin
          wq.push_back('{cyc + 1, r, s});
        end
      end
    end else if (fl) begin
      m_pend = 1'b0;
    end else if (ack) begin
      m_pend = 1'b0;
      if (m_pwe && m_lat_rd != 5'd0) wq.push_back('{cyc + 1, m_lat_rd, m_lat_sel});
    end else if (TO_EN && m_wait == T - 1) begin
      m_pend = 1'b0;
      fq.push_back(cyc + 1);
    end else begin
      m_wait++;
      exp_stall = 1'b1;
    end
    #1;
    chk("stall", stall, exp_stall);
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 5'd0, 1'b0, ack, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sel"}, sel_reg, 0);
    chk({tag, "_rd"}, rd_reg, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_stall"}, stall, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // ALU to x5
    step(1'b1, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    // load to x7, ack three cycles after issue
    step(1'b1, 3'b001, 5'd7, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    // PC+4 to x0 must not strobe
    step(1'b1, 3'b101, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    // pending load, flush together with ack
    step(1'b1, 3'b001, 5'd9, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b0);
    // load never acked within the timeout window
    step(1'b1, 3'b001, 5'd12, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    // flush suppresses same-cycle issue; load with immediate ack
    step(1'b1, 3'b000, 5'd3, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'b001, 5'd4, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b0);

    // asynchronous reset while waiting for a load
    step(1'b1, 3'b001, 5'd11, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    issue_valid = 1'b0;
    dmem_ack    = 1'b0;
    flush       = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    m_pend = 1'b0;
    m_lat_rd = 5'd0;
    m_lat_sel = 3'd0;
    wq.delete();
    fq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'b010, 5'd6, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);

    for (int i = 0; i < 600; i++) begin
      bit         iv;
      logic [2:0] s;
      logic [4:0] r;
      iv = !m_pend && ($urandom_range(0, 2) != 0);
      s  = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'($urandom_range(0, 5));
      r  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step(iv, s, r, 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end
    idle(3, 1'b1);
    idle(2, 1'b0);
    chk("wq_drained", wq.size(), 0);
    chk("fq_drained", fq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msrv32_wb_sched.md
# msrv32_wb_sched

Writeback scheduler for the msrv32 core: sequences the writeback stage that feeds `msrv32_wb_mux_sel_unit` and the register file write port. It registers the writeback source select, destination register and write enable for each issued instruction. It holds the pipeline via a stall while a load waits for data-memory acknowledge, and drops writebacks on flush or load timeout. It sits between the decode/issue stage register and the writeback mux / integer register file.

## Interface
- `TIMEOUT_CYCLES`, 16, max cycles spent waiting for `dmem_ack_in` before a load fault (≥2)
- `clk_in`  input  1  core clock, rising edge
- `rst_n_in`  input  1  asynchronous, active-low reset
- `issue_valid_in`  input  1  instruction presented to writeback this cycle
- `wb_sel_in`  input  3  writeback source select (package encoding)
- `rd_in`  input  5  destination register
- `rf_we_in`  input  1  instruction writes rd
- `dmem_ack_in`  input  1  load data valid on `lu_output_in` this cycle
- `flush_in`  input  1  trap/redirect; cancels current and pending writeback
- `wb_mux_sel_reg_out`  output  3  registered select to the writeback mux
- `rd_reg_out`  output  5  registered destination register
- `rf_wr_en_out`  output  1  register file write strobe, one cycle per write
- `stall_out`  output  1  combinational pipeline hold
- `load_fault_out`  output  1  one-cycle pulse on load timeout

## Operation
- FSM states: IDLE, WAIT_LD. Reset → IDLE.
- Issue is accepted only in IDLE. `issue_valid_in` while in WAIT_LD is illegal; it is ignored and flagged by assertion.
- IDLE, `issue_valid_in`, `wb_sel_in` ≠ WB_LU: latch select and rd; write next cycle.
- IDLE, WB_LU with `dmem_ack_in`: same as a non-load; no stall.
- IDLE, WB_LU without ack: latch select and rd; go WAIT_LD; `stall_out`=1 this cycle.
- WAIT_LD, ack: write next cycle; go IDLE; `stall_out`=0 this cycle.
- WAIT_LD, no ack: stay; `stall_out`=1; wait counter increments.
- Write strobe: `rf_wr_en_out` = `rf_we_in` (latched at issue) AND rd ≠ 0. A write to x0 never strobes.
- Flush in IDLE suppresses the same-cycle issue. Flush in WAIT_LD returns to IDLE with no write, no fault. Flush has priority over ack and timeout.
- Timeout: counter reaching `TIMEOUT_CYCLES`-1 in WAIT_LD without ack → `load_fault_out` pulse, go IDLE, no write, stall released. Ack in the same cycle wins over timeout.
- Counter clears on entry to WAIT_LD and on leaving it. Counter width is clog2(`TIMEOUT_CYCLES`+1) bits.
- `stall_out` = (IDLE & issue_valid & sel==WB_LU & ~ack & ~flush) | (WAIT_LD & ~ack & ~flush & ~timeout).

## Timing
- Reset values: `wb_mux_sel_reg_out`=3'b000, `rd_reg_out`=0, `rf_wr_en_out`=0, `load_fault_out`=0, counter 0. `stall_out`=0 (IDLE with no issue).
- Non-load latency: issue at cycle N → `rf_wr_en_out` at N+1.
- Load latency: ack at cycle M → write at M+1.
- `wb_mux_sel_reg_out` / `rd_reg_out` update at issue and hold until the next accepted issue, including across stalls.
- Reset asserted mid-WAIT_LD: immediate return to reset values, no write, no fault.

## Configuration
- `MSRV32_WB_TIMEOUT_EN` defined: wait counter and fault path are present as described.
- Not defined: no counter. WAIT_LD exits only on ack or flush, and `load_fault_out` is tied to 0.

## Structure
- Shared package `msrv32_pkg` holds the writeback select encodings: WB_ALU=000, WB_LU=001, WB_IMM=010, WB_IADDER=011, WB_CSR=100, WB_PC_PLUS=101. It also holds the FSM state typedef.
- One natural sub-module: `msrv32_wb_timeout_ctr`, the wait counter with clear/enable/expire. It is instantiated only under `MSRV32_WB_TIMEOUT_EN`.

## Test plan
- Issue WB_ALU, rd=5, we=1 → next cycle `rf_wr_en_out`=1, `rd_reg_out`=5, `wb_mux_sel_reg_out`=000, no stall.
- Issue WB_LU, rd=7, ack 3 cycles later → stall high for 3 cycles, low in the ack cycle; write rd=7 in the cycle after ack.
- Issue WB_PC_PLUS, rd=0, we=1 → `wb_mux_sel_reg_out`=101, `rf_wr_en_out` stays 0.
- WB_LU pending with flush and ack in the same cycle → IDLE, no write, no fault, stall drops.
- With timeout enabled and `TIMEOUT_CYCLES`=4, WB_LU with no ack → stall for 4 cycles, then one `load_fault_out` pulse, no write. Without the macro, stall holds until ack.
- Deassert `rst_n_in` mid-WAIT_LD → all outputs 0 asynchronously; after release, a WB_IMM issue writes normally.
